// File: rtl/jpeg_decoder_bitbuffer_pkg.sv
// rtl/jpeg_decoder_bitbuffer_pkg.sv - shared constants and types for the JPEG bit buffer
package jpeg_decoder_pkg;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam int         ACC_W              = 64;
  localparam int         WIN_W              = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    GOT_FF = 1'b1
  } unstuff_state_t;
endpackage

// File: rtl/jpeg_decoder_bitbuffer_if.sv
// rtl/jpeg_decoder_bitbuffer_if.sv - word FIFO, Huffman window and marker signals of the bit buffer
interface jpeg_decoder_bitbuffer_if;
  logic        inport_valid_i;
  logic [31:0] inport_data_i;
  logic        inport_pop_o;
  logic        flush_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        pop_i;
  logic [5:0]  pop_bits_i;
  logic [6:0]  level_o;
  logic        marker_valid_o;
  logic [7:0]  marker_o;
  logic        marker_ack_i;

  modport slave (
    input  inport_valid_i, inport_data_i, flush_i, pop_i, pop_bits_i, marker_ack_i,
    output inport_pop_o, data_o, valid_o, level_o, marker_valid_o, marker_o
  );

  modport master (
    output inport_valid_i, inport_data_i, flush_i, pop_i, pop_bits_i, marker_ack_i,
    input  inport_pop_o, data_o, valid_o, level_o, marker_valid_o, marker_o
  );
endinterface

// File: rtl/jpeg_decoder_bitbuffer_unstuff.sv
// rtl/jpeg_decoder_bitbuffer_unstuff.sv - byte unstuffing FSM with marker capture
module jpeg_decoder_unstuff
  import jpeg_decoder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_byte_i,
  input  logic       marker_ack_i,
  output logic       out_valid_o,
  output logic [7:0] out_byte_o,
  output logic       marker_valid_o,
  output logic [7:0] marker_o
);
  unstuff_state_t r_state;
  logic           r_marker_valid;
  logic [7:0]     r_marker;
  logic           w_is_ff;
  logic           w_is_zero;

  assign w_is_ff        = (in_byte_i == JPEG_MARKER_PREFIX);
  assign w_is_zero      = (in_byte_i == 8'h00);
  assign marker_valid_o = r_marker_valid;
  assign marker_o       = r_marker;

  // Output byte is produced in the same cycle the input byte is accepted.
  always_comb begin
    out_valid_o = 1'b0;
    out_byte_o  = in_byte_i;
    if (in_valid_i) begin
      if (r_state == NORMAL) begin
        out_valid_o = !w_is_ff;
      end else if (w_is_zero) begin
        out_valid_o = 1'b1;
        out_byte_o  = JPEG_MARKER_PREFIX;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_state        <= NORMAL;
      r_marker_valid <= 1'b0;
      r_marker       <= 8'h00;
    end else begin
      if (marker_ack_i && r_marker_valid) begin
        r_marker_valid <= 1'b0;
      end
      if (in_valid_i) begin
        case (r_state)
          NORMAL: begin
            if (w_is_ff) r_state <= GOT_FF;
          end
          GOT_FF: begin
            if (w_is_zero) begin
              r_state <= NORMAL;
            end else if (!w_is_ff) begin
              r_state        <= NORMAL;
              r_marker_valid <= 1'b1;
              r_marker       <= in_byte_i;
            end
          end
          default: r_state <= NORMAL;
        endcase
      end
    end
  end
endmodule

// File: rtl/jpeg_decoder_bitbuffer.sv
// rtl/jpeg_decoder_bitbuffer.sv - splits FIFO words into bytes, unstuffs them and
// presents an MSB-aligned 32-bit window from a 64-bit accumulator
module jpeg_decoder_bitbuffer
  import jpeg_decoder_pkg::*;
(
  input logic                      clk_i,
  input logic                      rst_i,
  jpeg_decoder_bitbuffer_if.slave  bus
);
  logic [ACC_W-1:0] r_acc;
  logic [6:0]       r_level;
  logic [1:0]       r_lane;

  logic             w_take;
  logic [7:0]       w_lane_byte;
  logic             w_app_valid;
  logic [7:0]       w_app_byte;
  logic             w_marker_valid;
  logic [7:0]       w_marker;
  logic             w_pop;
  logic [6:0]       w_pop_n;
  logic [6:0]       w_level_pop;
  logic [ACC_W-1:0] w_acc_pop;
  logic [ACC_W-1:0] w_app_bits;
  logic [WIN_W-1:0] w_fill;

  assign w_lane_byte      = bus.inport_data_i[{r_lane, 3'b000} +: 8];
  assign w_take           = bus.inport_valid_i && !w_marker_valid && (r_level <= 7'd56);
  assign bus.inport_pop_o = w_take && (r_lane == 2'd3);

  jpeg_decoder_unstuff u_unstuff (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (bus.flush_i),
    .in_valid_i     (w_take),
    .in_byte_i      (w_lane_byte),
    .marker_ack_i   (bus.marker_ack_i),
    .out_valid_o    (w_app_valid),
    .out_byte_o     (w_app_byte),
    .marker_valid_o (w_marker_valid),
    .marker_o       (w_marker)
  );

  assign bus.valid_o        = (r_level >= 7'd32) || (w_marker_valid && (r_level != 7'd0));
  assign bus.marker_valid_o = w_marker_valid;
  assign bus.marker_o       = w_marker;
  assign bus.level_o        = r_level;

  // Shift out consumed bits first, then drop the new byte right after the survivors.
  assign w_pop       = bus.pop_i && bus.valid_o && (bus.pop_bits_i != 6'd0);
  assign w_pop_n     = w_pop ? {1'b0, bus.pop_bits_i} : 7'd0;
  assign w_acc_pop   = r_acc << w_pop_n;
  assign w_level_pop = (w_pop_n > r_level) ? 7'd0 : (r_level - w_pop_n);
  assign w_app_bits  = {w_app_byte, {(ACC_W-8){1'b0}}} >> w_level_pop;

  // Bits past the fill level read as ones; the accumulator itself keeps them zero.
  assign w_fill      = (r_level >= 7'd32) ? {WIN_W{1'b0}} : ({WIN_W{1'b1}} >> r_level);
  assign bus.data_o  = (r_level == 7'd0) ? {WIN_W{1'b0}} : (r_acc[ACC_W-1 -: WIN_W] | w_fill);

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      r_acc   <= '0;
      r_level <= 7'd0;
      r_lane  <= 2'd0;
    end else begin
      if (w_take) begin
        r_lane <= r_lane + 2'd1;
      end
      if (w_app_valid) begin
        r_acc   <= w_acc_pop | w_app_bits;
        r_level <= w_level_pop + 7'd8;
      end else begin
        r_acc   <= w_acc_pop;
        r_level <= w_level_pop;
      end
    end
  end
endmodule

// File: tb/tb_jpeg_decoder_bitbuffer.sv
// tb/tb_jpeg_decoder_bitbuffer.sv - directed cases plus random stuffed streams checked
// against a byte-level unstuffing model through a bit scoreboard
module tb_jpeg_decoder_bitbuffer;
  localparam int N_BYTES = 400;
  localparam int LIMIT   = 20000;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  jpeg_decoder_bitbuffer_if bb();
  jpeg_decoder_bitbuffer dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bb));

  int n_checks = 0;
  int n_fail   = 0;
  int n_word_pops;

  logic [7:0]  sbytes[$];
  logic [31:0] words[$];
  bit          exp_bits[$];
  int          seg_len[$];
  logic [7:0]  seg_marker[$];
  int          open_len;
  bit          m_got_ff;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic feed(input logic [31:0] w, input int lanes);
    for (int i = 0; i < lanes; i++) begin
      bb.inport_valid_i = 1'b1;
      bb.inport_data_i  = w;
      #1;
      if (bb.inport_pop_o) n_word_pops++;
      @(negedge clk_i);
    end
    bb.inport_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    bb.flush_i = 1'b1;
    @(negedge clk_i);
    bb.flush_i  = 1'b0;
    n_word_pops = 0;
  endtask

  task automatic do_pop(input int n);
    bb.pop_i      = 1'b1;
    bb.pop_bits_i = 6'(n);
    @(negedge clk_i);
    bb.pop_i = 1'b0;
  endtask

  // Reference: the JPEG unstuffing rules applied to one stream byte.
  function automatic void model_byte(input logic [7:0] b);
    if (!m_got_ff) begin
      if (b == 8'hFF) m_got_ff = 1'b1;
      else begin
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        open_len += 8;
      end
    end else if (b == 8'h00) begin
      for (int i = 0; i < 8; i++) exp_bits.push_back(1'b1);
      open_len += 8;
      m_got_ff = 1'b0;
    end else if (b != 8'hFF) begin
      seg_len.push_back(open_len);
      seg_marker.push_back(b);
      open_len = 0;
      m_got_ff = 1'b0;
    end
  endfunction

  initial begin
    logic [127:0] s128;
    int r;

    bb.inport_valid_i = 1'b0;
    bb.inport_data_i  = '0;
    bb.flush_i        = 1'b0;
    bb.pop_i          = 1'b0;
    bb.pop_bits_i     = '0;
    bb.marker_ack_i   = 1'b0;
    n_word_pops       = 0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    check("rst_data", bb.data_o, 0);
    check("rst_valid", bb.valid_o, 0);
    check("rst_level", bb.level_o, 0);
    check("rst_mvalid", bb.marker_valid_o, 0);
    check("rst_marker", bb.marker_o, 0);

    // two plain words, then a full-window pop
    feed(32'h44332211, 4);
    feed(32'h88776655, 4);
    check("t1_data", bb.data_o, 32'h11223344);
    check("t1_valid", bb.valid_o, 1);
    check("t1_level", bb.level_o, 64);
    check("t1_wpops", n_word_pops, 2);
    do_pop(32);
    check("t1_data2", bb.data_o, 32'h55667788);
    check("t1_level2", bb.level_o, 32);

    // stuffed FF00 inside the stream
    do_flush();
    feed(32'h3400FF12, 4);
    feed(32'h00007856, 2);
    check("t2_data", bb.data_o, 32'h12FF3456);
    check("t2_level", bb.level_o, 40);
    check("t2_mvalid", bb.marker_valid_o, 0);

    // fill byte then marker, with a partial window
    do_flush();
    feed(32'hD9FFFFAB, 4);
    check("t3_mvalid", bb.marker_valid_o, 1);
    check("t3_marker", bb.marker_o, 8'hD9);
    check("t3_level", bb.level_o, 8);
    check("t3_valid", bb.valid_o, 1);
    check("t3_data", bb.data_o, 32'hABFFFFFF);
    do_pop(8);
    check("t3_level2", bb.level_o, 0);
    check("t3_valid2", bb.valid_o, 0);

    // marker split across words, halt, ack, resume at lane 1
    do_flush();
    feed(32'hFF030201, 4);
    feed(32'h070605D0, 1);
    check("t4_mvalid", bb.marker_valid_o, 1);
    check("t4_marker", bb.marker_o, 8'hD0);
    check("t4_data", bb.data_o, 32'h010203FF);
    feed(32'h070605D0, 2);
    check("t4_halt_level", bb.level_o, 24);
    check("t4_halt_wpops", n_word_pops, 1);
    bb.marker_ack_i   = 1'b1;
    bb.inport_valid_i = 1'b1;
    @(negedge clk_i);
    bb.marker_ack_i = 1'b0;
    check("t4_ack_mvalid", bb.marker_valid_o, 0);
    check("t4_ack_marker", bb.marker_o, 8'hD0);
    check("t4_ack_level", bb.level_o, 24);
    feed(32'h070605D0, 3);
    check("t4_resume_level", bb.level_o, 48);
    check("t4_resume_data", bb.data_o, 32'h01020305);
    check("t4_resume_wpops", n_word_pops, 2);

    // room check at the 56/57 boundary and pop+append in one cycle
    do_flush();
    feed(32'h44332211, 4);
    feed(32'h88776655, 4);
    bb.inport_valid_i = 1'b1;
    bb.inport_data_i  = 32'hCCBBAA99;
    do_pop(7);
    check("t5_level57", bb.level_o, 57);
    @(negedge clk_i);
    check("t5_hold57", bb.level_o, 57);
    do_pop(1);
    check("t5_level56", bb.level_o, 56);
    do_pop(13);
    bb.inport_valid_i = 1'b0;
    check("t5_level51", bb.level_o, 51);
    s128 = {64'h1122334455667788, 8'h99, 56'h0};
    check("t5_data", bb.data_o, s128[127-21 -: 32]);

    // flush while halted on a marker
    do_flush();
    feed(32'h0605D8FF, 3);
    check("t6_mvalid_pre", bb.marker_valid_o, 1);
    do_flush();
    check("t6_data", bb.data_o, 0);
    check("t6_valid", bb.valid_o, 0);
    check("t6_level", bb.level_o, 0);
    check("t6_mvalid", bb.marker_valid_o, 0);
    check("t6_marker", bb.marker_o, 0);
    // flush with FF pending mid-word: next word restarts at lane 0 in NORMAL
    feed(32'h0000FF01, 2);
    do_flush();
    feed(32'h04030200, 4);
    check("t6_data2", bb.data_o, 32'h00020304);
    check("t6_level2", bb.level_o, 32);
    check("t6_wpops", n_word_pops, 1);

    // random stuffed stream ending in an EOI marker
    while (sbytes.size() < N_BYTES - 6) begin
      r = $urandom_range(0, 99);
      if (r < 70) sbytes.push_back(8'($urandom_range(0, 254)));
      else if (r < 80) begin sbytes.push_back(8'hFF); sbytes.push_back(8'h00); end
      else if (r < 87) begin sbytes.push_back(8'hFF); sbytes.push_back(8'hFF); sbytes.push_back(8'h00); end
      else if (r < 94) begin sbytes.push_back(8'hFF); sbytes.push_back(8'($urandom_range(1, 254))); end
      else begin
        sbytes.push_back(8'hFF); sbytes.push_back(8'hFF); sbytes.push_back(8'($urandom_range(1, 254)));
      end
    end
    while (sbytes.size() < N_BYTES - 2) sbytes.push_back(8'($urandom_range(0, 254)));
    sbytes.push_back(8'hFF);
    sbytes.push_back(8'hD9);

    m_got_ff = 1'b0;
    open_len = 0;
    for (int k = 0; k < N_BYTES; k += 4) begin
      for (int j = 0; j < 4; j++) model_byte(sbytes[k+j]);
      words.push_back({sbytes[k+3], sbytes[k+2], sbytes[k+1], sbytes[k]});
    end

    do_flush();
    fork
      begin : producer
        int cyc;
        cyc = 0;
        while (words.size() != 0 && cyc < LIMIT) begin
          bb.inport_valid_i = ($urandom_range(0, 3) != 0);
          bb.inport_data_i  = words[0];
          #1;
          if (bb.inport_valid_i && bb.inport_pop_o) void'(words.pop_front());
          @(negedge clk_i);
          cyc++;
        end
        bb.inport_valid_i = 1'b0;
      end
      begin : consumer
        int cyc2, rem, n, take;
        logic [31:0] win;
        cyc2 = 0;
        while (seg_len.size() != 0 && cyc2 < LIMIT) begin
          bb.pop_i        = 1'b0;
          bb.marker_ack_i = 1'b0;
          rem = seg_len[0];
          if (bb.valid_o) begin
            win = '1;
            for (int i = 0; i < 32; i++) if (i < rem) win[31-i] = exp_bits[i];
            check("rnd_window", bb.data_o, win);
            if (bb.marker_valid_o) begin
              check("rnd_marker_level", bb.level_o, rem);
              check("rnd_marker_code", bb.marker_o, seg_marker[0]);
            end
            if ($urandom_range(0, 3) != 0) begin
              n = $urandom_range(1, 32);
              bb.pop_i      = 1'b1;
              bb.pop_bits_i = 6'(n);
              take = (n < rem) ? n : rem;
              repeat (take) void'(exp_bits.pop_front());
              seg_len[0] = rem - take;
            end
          end else if (bb.marker_valid_o) begin
            check("rnd_marker_code", bb.marker_o, seg_marker[0]);
            check("rnd_marker_empty", bb.level_o, rem);
            bb.marker_ack_i = 1'b1;
            void'(seg_len.pop_front());
            void'(seg_marker.pop_front());
          end
          @(negedge clk_i);
          cyc2++;
        end
        bb.pop_i        = 1'b0;
        bb.marker_ack_i = 1'b0;
        if (seg_len.size() != 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_timeout: %0d segments left, required 0", seg_len.size());
        end
      end
    join

    check("rnd_bits_left", exp_bits.size(), 0);
    check("rnd_words_left", words.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
